// File: rtl/axil_if.sv
// ============================================================================
// axil_if : AXI-Lite bus bundle (master/slave modports) for the timer port.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface axil_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

`default_nettype wire

// File: rtl/axil_timer.sv
// ============================================================================
// axil_timer : AXI-Lite 32-bit up-counting timer, compare match, auto-reload,
//              level irq. Optional prescaler: AXIL_TIMER_PRESCALE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axil_timer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  wire logic clk,
  input  wire logic rst,
  axil_if.slave     s_axil,
  output logic      irq
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam logic [IDX_W-1:0] IDX_CTRL     = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_STATUS   = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_COUNT    = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_COMPARE  = IDX_W'(3);
  localparam logic [IDX_W-1:0] IDX_PRESCALE = IDX_W'(4);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [DATA_WIDTH-1:0] strobed(
    input logic [DATA_WIDTH-1:0] old_val,
    input logic [DATA_WIDTH-1:0] new_val,
    input logic [STRB_WIDTH-1:0] strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_val;
    for (int b = 0; b < STRB_WIDTH; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

  logic [2:0]            ctrl;
  logic                  match;
  logic [DATA_WIDTH-1:0] count;
  logic [DATA_WIDTH-1:0] compare;
  logic                  tick;
  logic [DATA_WIDTH-1:0] prescale_rd;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  rd_mapped;

  wire logic             enable      = ctrl[0];
  wire logic             auto_reload = ctrl[1];
  wire logic             irq_en      = ctrl[2];

  wire logic [IDX_W-1:0] wr_idx    = s_axil.awaddr[ADDR_WIDTH-1:2];
  wire logic [IDX_W-1:0] rd_idx    = s_axil.araddr[ADDR_WIDTH-1:2];
  wire logic             wr_en     = s_axil.awready & s_axil.awvalid & s_axil.wvalid;
  wire logic             rd_en     = s_axil.arready & s_axil.arvalid;
  wire logic             wr_mapped = (wr_idx <= IDX_PRESCALE);
  wire logic             status_clr = wr_en && (wr_idx == IDX_STATUS)
                                      && s_axil.wstrb[0] && s_axil.wdata[0];

  logic unused_bits;
  assign unused_bits = ^{s_axil.awprot, s_axil.arprot,
                         s_axil.awaddr[1:0], s_axil.araddr[1:0]};

`ifdef AXIL_TIMER_PRESCALE_EN
  logic [DATA_WIDTH-1:0] prescale;
  logic [DATA_WIDTH-1:0] psc_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale <= '0;
      psc_cnt  <= '0;
    end else if (wr_en && wr_idx == IDX_PRESCALE) begin
      prescale <= strobed(prescale, s_axil.wdata, s_axil.wstrb);
      psc_cnt  <= '0;
    end else if (enable) begin
      psc_cnt  <= tick ? '0 : psc_cnt + 1'b1;
    end
  end

  assign tick        = enable && (psc_cnt == prescale);
  assign prescale_rd = prescale;
`else
  assign tick        = enable;
  assign prescale_rd = '0;
`endif

  always_comb begin
    rd_val    = '0;
    rd_mapped = 1'b1;
    case (rd_idx)
      IDX_CTRL:     rd_val = {{(DATA_WIDTH-3){1'b0}}, ctrl};
      IDX_STATUS:   rd_val = {{(DATA_WIDTH-1){1'b0}}, match};
      IDX_COUNT:    rd_val = count;
      IDX_COMPARE:  rd_val = compare;
      IDX_PRESCALE: rd_val = prescale_rd;
      default:      rd_mapped = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_axil.awready <= 1'b0;
      s_axil.wready  <= 1'b0;
      s_axil.bvalid  <= 1'b0;
      s_axil.bresp   <= RESP_OKAY;
      s_axil.arready <= 1'b0;
      s_axil.rvalid  <= 1'b0;
      s_axil.rresp   <= RESP_OKAY;
      s_axil.rdata   <= '0;
      ctrl           <= '0;
      match          <= 1'b0;
      count          <= '0;
      compare        <= '0;
    end else begin
      // Single-cycle accept pulse; the !awready term keeps it from repeating.
      s_axil.awready <= s_axil.awvalid & s_axil.wvalid & ~s_axil.bvalid & ~s_axil.awready;
      s_axil.wready  <= s_axil.awvalid & s_axil.wvalid & ~s_axil.bvalid & ~s_axil.awready;
      if (wr_en) begin
        s_axil.bvalid <= 1'b1;
        s_axil.bresp  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axil.bready) begin
        s_axil.bvalid <= 1'b0;
      end

      s_axil.arready <= s_axil.arvalid & ~s_axil.rvalid & ~s_axil.arready;
      if (rd_en) begin
        s_axil.rvalid <= 1'b1;
        s_axil.rdata  <= rd_val;
        s_axil.rresp  <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axil.rready) begin
        s_axil.rvalid <= 1'b0;
      end

      if (wr_en && wr_idx == IDX_CTRL && s_axil.wstrb[0]) begin
        ctrl <= s_axil.wdata[2:0];
      end
      if (wr_en && wr_idx == IDX_COMPARE) begin
        compare <= strobed(compare, s_axil.wdata, s_axil.wstrb);
      end

      // Bus write to COUNT takes priority over the tick update.
      if (wr_en && wr_idx == IDX_COUNT) begin
        count <= strobed(count, s_axil.wdata, s_axil.wstrb);
      end else if (tick) begin
        count <= (count == compare && auto_reload) ? '0 : count + 1'b1;
      end

      // Hardware set wins over a coincident W1C clear.
      if (tick && count == compare) begin
        match <= 1'b1;
      end else if (status_clr) begin
        match <= 1'b0;
      end
    end
  end

  assign irq = match & irq_en;

endmodule

`default_nettype wire

// File: tb/tb_axil_timer.sv
// ============================================================================
// tb_axil_timer : directed + randomized checks of axil_timer against a
//                 tick-level reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axil_timer;

  localparam int LIMIT = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        irq;
  int unsigned cyc = 0;
  int          total = 0;
  int          bad = 0;

  axil_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

  axil_timer #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
    .clk    (clk),
    .rst    (rst),
    .s_axil (bus),
    .irq    (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

`ifdef AXIL_TIMER_PRESCALE_EN
  localparam bit HAS_PSC = 1'b1;
`else
  localparam bit HAS_PSC = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts and ends on a falling edge; edge_n is the index of the accept edge.
  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic [1:0] resp, output int unsigned edge_n);
    int n;
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < LIMIT) begin @(negedge clk); n++; end
    if (n >= LIMIT) chk("wr_accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    @(negedge clk);
    edge_n = cyc;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    n = 0;
    while (!bus.bvalid && n < LIMIT) begin @(negedge clk); n++; end
    if (n >= LIMIT) chk("wr_resp_timeout", 32'd1, 32'd0);
    resp = bus.bresp;
    @(negedge clk);
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    bus.araddr = a; bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < LIMIT) begin @(negedge clk); n++; end
    if (n >= LIMIT) chk("rd_accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.arvalid = 1'b0;
    n = 0;
    while (!bus.rvalid && n < LIMIT) begin @(negedge clk); n++; end
    if (n >= LIMIT) chk("rd_resp_timeout", 32'd1, 32'd0);
    d = bus.rdata; resp = bus.rresp;
    @(negedge clk);
  endtask

  // Run the timer for a stretch, then compare against the tick-level model.
  task automatic trial(input logic [31:0] c0, input logic [31:0] cmp, input logic [31:0] p,
                       input bit ar, input bit ie, input int hold);
    logic [1:0]  r;
    logic [31:0] d, c;
    int unsigned e1, e2, n_cyc, n_ticks, e_dummy;
    bit          m;
    logic [31:0] off;
    off = {29'd0, ie, ar, 1'b0};
    wr(12'h000, off, 4'hF, r, e_dummy);
    wr(12'h004, 32'h1, 4'hF, r, e_dummy);
    wr(12'h008, c0, 4'hF, r, e_dummy);
    wr(12'h00C, cmp, 4'hF, r, e_dummy);
    wr(12'h010, p, 4'hF, r, e_dummy);
    wr(12'h000, off | 32'h1, 4'hF, r, e1);
    repeat (hold) @(negedge clk);
    wr(12'h000, off, 4'hF, r, e2);
    n_cyc   = e2 - e1;
    n_ticks = n_cyc / ((HAS_PSC ? p : 32'd0) + 32'd1);
    c = c0; m = 1'b0;
    for (int t = 0; t < int'(n_ticks); t++) begin
      if (c == cmp) begin
        m = 1'b1;
        c = ar ? 32'd0 : c + 32'd1;
      end else begin
        c = c + 32'd1;
      end
    end
    rd(12'h008, d, r); chk("trial_count", d, c);
    rd(12'h004, d, r); chk("trial_status", d, {31'd0, m});
    chk("trial_irq", {31'd0, irq}, {31'd0, m & ie});
  endtask

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    int unsigned e, e_dummy;
    int          n;

    rst = 1'b1;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b1;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs",
        {8'd0, bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid, irq, bus.bresp, bus.rresp, 16'd0},
        32'd0);
    chk("reset_rdata", bus.rdata, 32'd0);
    rd(12'h008, d, r);
    chk("reset_count", d, 32'd0);
    chk("reset_count_resp", {30'd0, r}, 32'd0);

    // COMPARE=5 auto-reload: irq rises on the 6th tick after enable.
    wr(12'h00C, 32'd5, 4'hF, r, e_dummy);
    wr(12'h010, 32'd0, 4'hF, r, e_dummy);
    wr(12'h000, 32'h7, 4'hF, r, e);
    while (cyc < e + 5) @(negedge clk);
    chk("irq_before_match", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("irq_at_match", {31'd0, irq}, 32'd1);

    // Freeze, then W1C clears the flag and drops irq.
    wr(12'h000, 32'h6, 4'hF, r, e_dummy);
    chk("irq_held", {31'd0, irq}, 32'd1);
    wr(12'h004, 32'h1, 4'hF, r, e_dummy);
    chk("irq_after_clear", {31'd0, irq}, 32'd0);
    rd(12'h004, d, r);
    chk("status_after_clear", d, 32'd0);

    // COMPARE=0 with auto-reload matches every tick, so every clear coincides.
    wr(12'h008, 32'd0, 4'hF, r, e_dummy);
    wr(12'h00C, 32'd0, 4'hF, r, e_dummy);
    wr(12'h000, 32'h7, 4'hF, r, e_dummy);
    wr(12'h004, 32'h1, 4'hF, r, e_dummy);
    rd(12'h004, d, r);
    chk("match_wins_over_clear", d, 32'd1);
    wr(12'h000, 32'h0, 4'hF, r, e_dummy);

    // Wrap past 0xFFFFFFFF without a match.
    trial(32'hFFFF_FFFE, 32'h10, 32'd0, 1'b0, 1'b1, 0);
    // Auto-reload period 6, and a prescaled run.
    trial(32'd0, 32'd5, 32'd0, 1'b1, 1'b1, 20);
    trial(32'd0, 32'd50, 32'd3, 1'b0, 1'b0, 40);

    // Byte strobe on COMPARE.
    wr(12'h00C, 32'd0, 4'hF, r, e_dummy);
    wr(12'h00C, 32'hAABB_CCDD, 4'b0010, r, e_dummy);
    rd(12'h00C, d, r);
    chk("strobe_compare", d, 32'h0000_CC00);

    // PRESCALE readback depends on the build.
    wr(12'h010, 32'h0000_0007, 4'hF, r, e_dummy);
    chk("prescale_wr_resp", {30'd0, r}, 32'd0);
    rd(12'h010, d, r);
    chk("prescale_rd", d, HAS_PSC ? 32'd7 : 32'd0);
    chk("prescale_rd_resp", {30'd0, r}, 32'd0);

    // Unmapped accesses.
    rd(12'h020, d, r);
    chk("unmapped_rdata", d, 32'd0);
    chk("unmapped_rresp", {30'd0, r}, 32'd2);
    wr(12'h020, 32'hFFFF_FFFF, 4'hF, r, e_dummy);
    chk("unmapped_bresp", {30'd0, r}, 32'd2);
    rd(12'h00C, d, r);
    chk("unmapped_no_effect", d, 32'h0000_CC00);

    // Back-pressure on B: second write must wait for the handshake.
    bus.bready = 1'b0;
    bus.awaddr = 12'h00C; bus.wdata = 32'h11; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < LIMIT) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    bus.wdata = 32'h22;
    for (int i = 0; i < 5; i++) begin
      chk("hold_bvalid", {31'd0, bus.bvalid}, 32'd1);
      chk("hold_awready", {30'd0, bus.awready, bus.wready}, 32'd0);
      @(negedge clk);
    end
    bus.bready = 1'b1;
    n = 0;
    while (!bus.awready && n < LIMIT) begin @(negedge clk); n++; end
    if (n >= LIMIT) chk("second_wr_timeout", 32'd1, 32'd0);
    @(posedge clk);
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    repeat (2) @(negedge clk);
    rd(12'h00C, d, r);
    chk("second_write_data", d, 32'h22);

    // Randomized runs.
    for (int k = 0; k < 10; k++) begin
      logic [31:0] c0, cmp, p;
      c0  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom_range(0, 30);
      cmp = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7)  : $urandom_range(0, 30);
      p   = $urandom_range(0, 3);
      trial(c0, cmp, p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 60));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/axil_timer.md
Name: axil_timer

Overview:
- AXI-Lite responder peripheral: a 32-bit up-counting timer with compare match, auto-reload and a level interrupt.
- Attaches as a new slave port on the SoC AXI-Lite interconnect, after memory, UART and GPIO, in a 4KB window. The CPU control unit drives it as initiator.
- Provides the periodic tick and delay source for firmware.

Parameters:
- DATA_WIDTH, 32, AXI-Lite data width; only 32 supported.
- ADDR_WIDTH, 12, local address width of the 4KB window.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- s_axil_awaddr  in  ADDR_WIDTH  write address.
- s_axil_awprot  in  3  ignored.
- s_axil_awvalid  in  1  write address valid.
- s_axil_awready  out  1  write address accepted.
- s_axil_wdata  in  32  write data.
- s_axil_wstrb  in  4  byte strobes.
- s_axil_wvalid  in  1  write data valid.
- s_axil_wready  out  1  write data accepted.
- s_axil_bresp  out  2  write response.
- s_axil_bvalid  out  1  write response valid.
- s_axil_bready  in  1  write response ready.
- s_axil_araddr  in  ADDR_WIDTH  read address.
- s_axil_arprot  in  3  ignored.
- s_axil_arvalid  in  1  read address valid.
- s_axil_arready  out  1  read address accepted.
- s_axil_rdata  out  32  read data.
- s_axil_rresp  out  2  read response.
- s_axil_rvalid  out  1  read data valid.
- s_axil_rready  in  1  read data ready.
- irq  out  1  level interrupt, equals STATUS.match & CTRL.irq_en.

Behaviour:
- Register map (byte offsets):
  - 0x00 CTRL: bit0 enable, bit1 auto_reload, bit2 irq_en; other bits read 0.
  - 0x04 STATUS: bit0 match; write-1-to-clear.
  - 0x08 COUNT: read/write.
  - 0x0C COMPARE: read/write.
  - 0x10 PRESCALE: read/write.
- Address decode: uses addr[ADDR_WIDTH-1:2]; addr[1:0] ignored.
  - Offsets >= 0x14 are unmapped.
  - Unmapped write: no effect, bresp=SLVERR (2'b10).
  - Unmapped read: rdata=0, rresp=SLVERR.
  - Mapped accesses respond OKAY.
- Reset: all registers 0; awready, wready, arready, bvalid, rvalid, irq all 0; bresp/rresp 0; rdata 0.
- Write channel:
  - awready and wready pulse high together for one cycle when awvalid & wvalid & !bvalid. Address and data are accepted in the same cycle; no independent AW/W buffering.
  - Register update takes effect in the accept cycle edge. Byte strobes are honoured per byte on CTRL/COUNT/COMPARE/PRESCALE.
  - STATUS clear needs wstrb[0] and wdata[0].
  - bvalid rises the cycle after accept and holds until bready. A new write is not accepted while bvalid=1.
- Read channel:
  - arready pulses one cycle when arvalid & !rvalid.
  - rvalid and rdata register the next cycle; rdata is a snapshot at the accept edge.
  - rvalid and rdata hold stable until rready. No new read is accepted while rvalid=1.
  - Reads and writes proceed independently and may complete in the same cycle.
- Prescaler:
  - 32-bit prescale counter runs while enable=1. When it equals PRESCALE it produces a one-cycle tick and returns to 0.
  - PRESCALE=0 gives a tick every cycle.
  - enable=0 holds both the counter and the prescaler at their current values; they are not reset.
- Counter, on tick:
  - COUNT==COMPARE: set match.
    - auto_reload=1: COUNT<=0.
    - auto_reload=0: COUNT<=COUNT+1.
  - Otherwise COUNT<=COUNT+1; wraps 0xFFFFFFFF -> 0 without setting match unless COMPARE matches.
- Simultaneous events:
  - A bus write to COUNT overrides the tick update in the same cycle.
  - A hardware match set wins over a W1C clear in the same cycle.
  - A PRESCALE write resets the prescale counter to 0.
- irq is combinational from registered state, so it has zero-cycle latency from the match flag.
- Reset asserted mid-transaction: the transaction is dropped, bvalid/rvalid go to 0 next edge and registers return to reset values. No response is owed for the dropped transaction.

Optional Feature:
- AXIL_TIMER_PRESCALE_EN defined: PRESCALE register and prescale counter are present as above.
- Not defined:
  - Tick is asserted every cycle while enable=1.
  - Offset 0x10 stays mapped: reads 0 with OKAY; writes are ignored with OKAY.
  - No prescale flops are synthesized.

Test Plan:
- Reset -> all outputs 0. Read 0x08 returns 0x00000000, OKAY.
- Write COMPARE=5, PRESCALE=0, CTRL=0x7 (enable, auto-reload, irq_en) -> COUNT cycles 0..5. match and irq rise on the tick where COUNT==5, then COUNT returns to 0.
- Write STATUS=0x1 after a match -> irq drops the cycle after the write accept.
- Clear timed coincident with the next match tick -> match stays 1.
- Write COUNT=0xFFFFFFFE, CTRL=0x1, COMPARE=0x10 -> COUNT goes 0xFFFFFFFF then 0x0, no match.
- With the macro defined: PRESCALE=3 -> COUNT increments once per 4 cycles.
- Byte-strobe write wdata=0xAABBCCDD, wstrb=4'b0010 to COMPARE (was 0) -> read back 0x0000CC00.
- Read 0x20 -> rresp=SLVERR, rdata=0.
- Write 0x20 -> bresp=SLVERR, no register change.
- Hold bready=0 for 5 cycles with awvalid/wvalid still asserted for a second write -> bvalid held, awready/wready stay 0 until bready handshake.
